// File: rtl/branch_history_table_pkg.sv
// branch_history_table_pkg: shared counter encodings, counter type and PC index helper.
//   SNT/WNT/WT/ST  2-bit saturating counter states
//   ctr_t          2-bit counter type
//   bht_index      word index of a PC, masked to index_bits bits
package branch_history_table_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t SNT = 2'b00;
    localparam ctr_t WNT = 2'b01;
    localparam ctr_t WT  = 2'b10;
    localparam ctr_t ST  = 2'b11;

    function automatic logic [31:0] bht_index(input logic [31:0] pc, input int unsigned index_bits);
        return (pc >> 2) & ((32'd1 << index_bits) - 32'd1);
    endfunction

endpackage

// File: rtl/branch_history_table_sat_counter2.sv
// sat_counter2: next-state logic of a 2-bit saturating up/down counter with load.
//   cur       current counter value
//   en        apply one up/down step
//   up        step direction (1 = increment)
//   load      replace value with load_val (wins over en)
//   load_val  value taken on load
//   nxt       next counter value
module sat_counter2
    import branch_history_table_pkg::*;
(
    input  ctr_t cur,
    input  logic en,
    input  logic up,
    input  logic load,
    input  ctr_t load_val,
    output ctr_t nxt
);

    assign nxt = load ? load_val :
                 !en  ? cur :
                 up   ? ((cur == ST)  ? ST  : cur + 2'd1) :
                        ((cur == SNT) ? SNT : cur - 2'd1);

endmodule

// File: rtl/branch_history_table.sv
// branch_history_table: 2-bit saturating-counter direction predictor indexed by PC[INDEX_BITS+1:2].
//   clk, rst_n       clock, asynchronous active-low reset
//   PC_IF            lookup address; pred_taken is counter[1] of its entry (combinational)
//   upd_valid        resolved branch this cycle: upd_pc, upd_taken, upd_pred describe it
//   bht_clear        reload every entry with INIT_STATE on the next edge (drops any update)
//   br_count         resolved branches (BHT_STATS_EN), else 0
//   mispred_count    upd_pred != upd_taken events (BHT_STATS_EN), else 0
// Optional feature macro: BHT_STATS_EN enables the saturating statistics counters.
module branch_history_table
    import branch_history_table_pkg::*;
#(
    parameter int   INDEX_BITS = 6,
    parameter ctr_t INIT_STATE = WNT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] PC_IF,
    output logic        pred_taken,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic        upd_pred,
    input  logic        bht_clear,
    output logic [31:0] br_count,
    output logic [31:0] mispred_count
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    ctr_t tbl [ENTRIES];
    logic [31:0] rd_full, wr_full;
    logic [INDEX_BITS-1:0] rd_idx, wr_idx;

    assign rd_full    = bht_index(PC_IF, INDEX_BITS);
    assign wr_full    = bht_index(upd_pc, INDEX_BITS);
    assign rd_idx     = rd_full[INDEX_BITS-1:0];
    assign wr_idx     = wr_full[INDEX_BITS-1:0];
    // No bypass: a same-cycle update to this entry is seen only after the edge.
    assign pred_taken = tbl[rd_idx][1];

    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        ctr_t nxt;
        sat_counter2 u_ctr (
            .cur      (tbl[i]),
            .en       (upd_valid && (wr_idx == INDEX_BITS'(i))),
            .up       (upd_taken),
            .load     (bht_clear),
            .load_val (INIT_STATE),
            .nxt      (nxt)
        );
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) tbl[i] <= INIT_STATE;
            else        tbl[i] <= nxt;
        end
    end

`ifdef BHT_STATS_EN
    // Counts ignore bht_clear; both stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count      <= '0;
            mispred_count <= '0;
        end else begin
            if (upd_valid && br_count != '1) br_count <= br_count + 32'd1;
            if (upd_valid && upd_pred != upd_taken && mispred_count != '1) mispred_count <= mispred_count + 32'd1;
        end
    end
    logic unused_bits;
    assign unused_bits = ^{rd_full[31:INDEX_BITS], wr_full[31:INDEX_BITS]};
`else
    assign br_count      = 32'd0;
    assign mispred_count = 32'd0;
    logic unused_bits;
    assign unused_bits = ^{rd_full[31:INDEX_BITS], wr_full[31:INDEX_BITS], upd_pred};
`endif

endmodule
